// File: rtl/multdiv_unit.sv
// multdiv_unit: multicycle signed 32-bit multiplier (radix-4 Booth) and divider
// with a registered result, exception flag and one-cycle ready pulse.
module multdiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nxt;
    logic [5:0]  cnt;
    logic [33:0] acc;
    logic [31:0] q, m;
    logic        q_1, neg, dzero, dovf;
    logic        start, fin_mul, fin_div;
    logic [2:0]  bb;
    logic [33:0] m_ext, booth_add, sum;
    logic [66:0] mul_cat, mul_sh;
    logic [32:0] shifted, diff;
    logic [63:0] prod;
    logic [31:0] quo, abs_a, abs_b;

    assign start   = ctrl_MULT | ctrl_DIV;
    assign fin_mul = state == MUL && cnt == 6'd16;
    assign fin_div = state == DIV && cnt == 6'd32;
    assign busy           = state != IDLE;
    assign data_resultRDY = state == DONE;

    always_comb begin
        state_nxt = start ? (ctrl_MULT ? MUL : DIV) :
                    state == DONE ? IDLE :
                    (fin_mul || fin_div) ? DONE : state;
    end

    // Booth recoding of {q[1:0], q_1}; acc carries two guard bits for the +/-2M step
    always_comb begin
        bb        = {q[1:0], q_1};
        m_ext     = {{2{m[31]}}, m};
        booth_add = (bb == 3'b001 || bb == 3'b010) ? m_ext :
                    bb == 3'b011 ? m_ext << 1 :
                    bb == 3'b100 ? -(m_ext << 1) :
                    (bb == 3'b101 || bb == 3'b110) ? -m_ext : 34'd0;
        sum       = acc + booth_add;
        mul_cat   = {sum, q, q_1};
        mul_sh    = {{2{sum[33]}}, mul_cat[66:2]};
        shifted   = {acc[31:0], q[31]};
        diff      = shifted - {1'b0, m};
        prod      = {acc[31:0], q};
        quo       = neg ? -q : q;
        abs_a     = data_operandA[31] ? -data_operandA : data_operandA;
        abs_b     = data_operandB[31] ? -data_operandB : data_operandB;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            q              <= '0;
            q_1            <= 1'b0;
            m              <= '0;
            neg            <= 1'b0;
            dzero          <= 1'b0;
            dovf           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                cnt   <= '0;
                acc   <= '0;
                q_1   <= 1'b0;
                q     <= ctrl_MULT ? data_operandB : abs_a;
                m     <= ctrl_MULT ? data_operandA : abs_b;
                neg   <= data_operandA[31] ^ data_operandB[31];
                dzero <= data_operandB == 32'd0;
                dovf  <= data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF;
            end else if (fin_mul) begin
                data_result    <= prod[31:0];
                data_exception <= ~(&prod[63:31] | ~|prod[63:31]);
            end else if (fin_div) begin
                data_result    <= dzero ? 32'd0 : quo;
                data_exception <= dzero | dovf;
            end else if (state == MUL) begin
                acc <= mul_sh[66:33];
                q   <= mul_sh[32:1];
                q_1 <= mul_sh[0];
                cnt <= cnt + 6'd1;
            end else if (state == DIV) begin
                acc <= {1'b0, diff[32] ? shifted : diff};
                q   <= {q[30:0], ~diff[32]};
                cnt <= cnt + 6'd1;
            end
        end
    end
endmodule
